// File: rtl/icetap_spi_bridge.sv
// SPI-slave bridge to a bank of scan channels: an address phase selects one
// channel, then every SPI clock shifts one bit into it while its return data goes out on MISO.
module icetap_spi_bridge #(
  parameter int NUM_CHAN    = 8,
  parameter int ADDR_BITS   = 8,
  parameter int CNT_BITS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                scan_clk,
  input  logic                scan_reset,
  input  logic                spi_clk,
  input  logic                spi_ss_,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic [NUM_CHAN-1:0] chan_shift_ena,
  output logic                chan_shift_data,
  output logic [NUM_CHAN-1:0] chan_capture,
  output logic [NUM_CHAN-1:0] chan_update,
  input  logic [NUM_CHAN-1:0] chan_shift_in,
  output logic                xfer_active,
  output logic [CNT_BITS-1:0] bit_count,
  output logic                addr_err
);

  localparam int ACNT_W = $clog2(ADDR_BITS + 1);
  localparam logic [ADDR_BITS:0] CHAN_LIMIT = (ADDR_BITS + 1)'(NUM_CHAN);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, ss_sync, mosi_sync;
  logic [SYNC_STAGES:0]   fill;
  logic                   clk_s, ss_s, mosi_s;
  logic                   clk_d, ss_d;
  logic                   edge_evt, ss_rise, fill_done;
  logic                   armed;
  state_t                 state;
  logic [ADDR_BITS-1:0]   addr, addr_next;
  logic [ACNT_W-1:0]      addr_cnt;
  logic                   addr_ok, miso_bit;
  logic [NUM_CHAN-1:0]    addr_oh, addr_next_oh;
  logic [CNT_BITS-1:0]    bc_next;

  function automatic logic [NUM_CHAN-1:0] chan_onehot(input logic [ADDR_BITS-1:0] a);
    chan_onehot = '0;
    for (int i = 0; i < NUM_CHAN; i++)
      if (a == ADDR_BITS'(i)) chan_onehot[i] = 1'b1;
  endfunction

  // NOTE: the SPI pins are asynchronous; nothing downstream may look at them
  // before they have crossed the full synchroniser chain.
  always_ff @(posedge scan_clk) begin
    if (scan_reset) begin
      clk_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      clk_d     <= 1'b0;
      ss_d      <= 1'b1;
      fill      <= '0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      clk_d     <= clk_s;
      ss_d      <= ss_s;
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign fill_done = fill[SYNC_STAGES];
  assign edge_evt  = clk_s & ~clk_d;
  assign ss_rise   = ss_s & ~ss_d;

  assign addr_next    = ADDR_BITS'({addr, mosi_s});
  assign addr_ok      = {1'b0, addr_next} < CHAN_LIMIT;
  assign addr_oh      = chan_onehot(addr);
  assign addr_next_oh = chan_onehot(addr_next);
  assign miso_bit     = |(chan_shift_in & addr_oh);
  assign bc_next      = (&bit_count) ? bit_count : bit_count + 1'b1;

  // A transaction starts only once ss_ has been seen high on the real pin, so
  // the reset-time preload of the ss_ chain can never fake a falling edge.
  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of one another, exactly as the flops will.
  always_ff @(posedge scan_clk) begin
    if (scan_reset) begin
      state           <= IDLE;
      armed           <= 1'b0;
      addr            <= '0;
      addr_cnt        <= '0;
      bit_count       <= '0;
      xfer_active     <= 1'b0;
      spi_miso        <= 1'b0;
      chan_shift_ena  <= '0;
      chan_shift_data <= 1'b0;
      chan_capture    <= '0;
      chan_update     <= '0;
      addr_err        <= 1'b0;
    end else begin
      chan_shift_ena  <= '0;
      chan_shift_data <= 1'b0;
      chan_capture    <= '0;
      chan_update     <= '0;
      addr_err        <= 1'b0;
      spi_miso        <= 1'b0;

      case (state)
        IDLE: begin
          if (armed && !ss_s) begin
            state       <= ADDR;
            armed       <= 1'b0;
            addr        <= '0;
            addr_cnt    <= '0;
            bit_count   <= '0;
            xfer_active <= 1'b1;
          end else if (fill_done && ss_s) begin
            armed <= 1'b1;
          end
        end

        ADDR: begin
          if (ss_rise) begin
            state       <= IDLE;
            xfer_active <= 1'b0;
          end else if (edge_evt) begin
            addr <= addr_next;
            if (addr_cnt == ACNT_W'(ADDR_BITS - 1)) begin
              if (addr_ok) begin
                state        <= DATA;
                chan_capture <= addr_next_oh;
              end else begin
                state       <= IGNORE;
                addr_err    <= 1'b1;
                xfer_active <= 1'b0;
              end
            end else begin
              addr_cnt <= addr_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          spi_miso <= miso_bit;
          if (ss_rise) begin
            if (bit_count != '0) chan_update <= addr_oh;
            state       <= IDLE;
            xfer_active <= 1'b0;
          end else if (edge_evt) begin
            chan_shift_ena  <= addr_oh;
            chan_shift_data <= mosi_s;
            bit_count       <= bc_next;
          end
        end

        IGNORE: begin
          if (ss_rise) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icetap_spi_bridge.sv
// Scoreboard bench for icetap_spi_bridge: each scenario queues the channel
// events it expects and a negedge monitor pops and compares what the DUT emits.
module tb_icetap_spi_bridge;

  localparam int NUM_CHAN  = 8;
  localparam int ADDR_BITS = 8;
  localparam int CNT_BITS  = 16;

  logic                scan_clk = 1'b0;
  logic                scan_reset = 1'b1;
  logic                spi_clk = 1'b0;
  logic                spi_ss_ = 1'b1;
  logic                spi_mosi = 1'b0;
  logic [NUM_CHAN-1:0] chan_shift_in = '0;
  logic                spi_miso;
  logic [NUM_CHAN-1:0] chan_shift_ena, chan_capture, chan_update;
  logic                chan_shift_data, xfer_active, addr_err;
  logic [CNT_BITS-1:0] bit_count;

  // Narrow-counter copy on the same pins, used only to see saturation.
  logic                s_miso, s_data, s_active, s_err;
  logic [NUM_CHAN-1:0] s_ena, s_cap, s_upd;
  logic [2:0]          s_count;

  icetap_spi_bridge #(.NUM_CHAN(NUM_CHAN), .ADDR_BITS(ADDR_BITS), .CNT_BITS(CNT_BITS)) dut (
    .scan_clk(scan_clk), .scan_reset(scan_reset), .spi_clk(spi_clk), .spi_ss_(spi_ss_),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .chan_shift_ena(chan_shift_ena),
    .chan_shift_data(chan_shift_data), .chan_capture(chan_capture), .chan_update(chan_update),
    .chan_shift_in(chan_shift_in), .xfer_active(xfer_active), .bit_count(bit_count),
    .addr_err(addr_err));

  icetap_spi_bridge #(.NUM_CHAN(NUM_CHAN), .ADDR_BITS(ADDR_BITS), .CNT_BITS(3)) dut_sat (
    .scan_clk(scan_clk), .scan_reset(scan_reset), .spi_clk(spi_clk), .spi_ss_(spi_ss_),
    .spi_mosi(spi_mosi), .spi_miso(s_miso), .chan_shift_ena(s_ena),
    .chan_shift_data(s_data), .chan_capture(s_cap), .chan_update(s_upd),
    .chan_shift_in(chan_shift_in), .xfer_active(s_active), .bit_count(s_count),
    .addr_err(s_err));

  always #5 scan_clk = ~scan_clk;

  typedef enum int {EV_CAP, EV_SHIFT, EV_UPD, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       chan;
    logic     data;
  } ev_t;

  ev_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic miso_hi = 1'b0;

  function automatic int first_set(input logic [NUM_CHAN-1:0] v);
    for (int i = 0; i < NUM_CHAN; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge scan_clk) begin
    int  n;
    ev_t obs;
    ev_t exp_ev;
    n = $countones(chan_shift_ena) + $countones(chan_capture) + $countones(chan_update);
    if (n > 1) begin
      checks++;
      errors++;
      $display("FAIL onehot: ena=%b cap=%b upd=%b, required at most one bit set",
               chan_shift_ena, chan_capture, chan_update);
    end else if (n == 1 || addr_err) begin
      obs.chan = 0;
      obs.data = 1'b0;
      if (addr_err) obs.kind = EV_ERR;
      else if (|chan_capture) begin obs.kind = EV_CAP; obs.chan = first_set(chan_capture); end
      else if (|chan_update) begin obs.kind = EV_UPD; obs.chan = first_set(chan_update); end
      else begin
        obs.kind = EV_SHIFT;
        obs.chan = first_set(chan_shift_ena);
        obs.data = chan_shift_data;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got kind=%0d chan=%0d data=%b, required none",
                 int'(obs.kind), obs.chan, obs.data);
      end else begin
        exp_ev = exp_q.pop_front();
        if (obs.kind !== exp_ev.kind || obs.chan !== exp_ev.chan ||
            (exp_ev.kind == EV_SHIFT && obs.data !== exp_ev.data)) begin
          errors++;
          $display("FAIL event: got kind=%0d chan=%0d data=%b, required kind=%0d chan=%0d data=%b",
                   int'(obs.kind), obs.chan, obs.data, int'(exp_ev.kind), exp_ev.chan, exp_ev.data);
        end
      end
    end
    if (spi_miso === 1'b1) miso_hi = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge scan_clk);
  endtask

  task automatic expect_ev(input ev_kind_t k, input int c, input logic d);
    ev_t e;
    e.kind = k;
    e.chan = c;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    tick(4);
    spi_clk = 1'b1;
    tick(4);
    spi_clk = 1'b0;
  endtask

  task automatic spi_start();
    spi_ss_ = 1'b0;
    tick(6);
  endtask

  task automatic spi_stop();
    tick(4);
    spi_ss_ = 1'b1;
    tick(8);
  endtask

  task automatic send_addr(input int a, input int nbits);
    for (int i = ADDR_BITS - 1; i >= ADDR_BITS - nbits; i--) spi_bit(a[i]);
  endtask

  task automatic run_data_xfer(input int ch, input logic [31:0] bits, input int n);
    expect_ev(EV_CAP, ch, 1'b0);
    for (int i = 0; i < n; i++) expect_ev(EV_SHIFT, ch, bits[n-1-i]);
    if (n > 0) expect_ev(EV_UPD, ch, 1'b0);
    spi_start();
    send_addr(ch, ADDR_BITS);
    for (int i = 0; i < n; i++) spi_bit(bits[n-1-i]);
    spi_stop();
  endtask

  task automatic test_reset();
    scan_reset = 1'b1;
    tick(4);
    checks++;
    if ({spi_miso, chan_shift_data, xfer_active, addr_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_scalars: got miso/data/active/err=%b, required 0000",
               {spi_miso, chan_shift_data, xfer_active, addr_err});
    end
    checks++;
    if ({chan_shift_ena, chan_capture, chan_update} !== '0) begin
      errors++;
      $display("FAIL reset_chan: got ena=%b cap=%b upd=%b, required all 0",
               chan_shift_ena, chan_capture, chan_update);
    end
    checks++;
    if (bit_count !== '0) begin
      errors++;
      $display("FAIL reset_bit_count: got %0d, required 0", bit_count);
    end
    scan_reset = 1'b0;
    tick(6);
  endtask

  task automatic test_basic();
    run_data_xfer(2, 32'hA5C, 12);
    checks++;
    if (bit_count !== 16'd12) begin
      errors++;
      $display("FAIL basic_bit_count: got %0d, required 12", bit_count);
    end
    checks++;
    if (s_count !== 3'd7) begin
      errors++;
      $display("FAIL bit_count_saturate: got %0d, required 7", s_count);
    end
    checks++;
    if (xfer_active !== 1'b0) begin
      errors++;
      $display("FAIL basic_active_after: got %b, required 0", xfer_active);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_drained: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_addr_err();
    chan_shift_in = '1;
    miso_hi = 1'b0;
    expect_ev(EV_ERR, 0, 1'b0);
    spi_start();
    send_addr(9, ADDR_BITS);
    tick(2);
    checks++;
    if (xfer_active !== 1'b0) begin
      errors++;
      $display("FAIL ignore_active: got %b, required 0", xfer_active);
    end
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1);
    spi_stop();
    checks++;
    if (miso_hi !== 1'b0) begin
      errors++;
      $display("FAIL ignore_miso: got miso high=%b, required 0", miso_hi);
    end
    checks++;
    if (bit_count !== '0) begin
      errors++;
      $display("FAIL ignore_bit_count: got %0d, required 0", bit_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL addr_err_drained: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
    chan_shift_in = '0;
  endtask

  task automatic test_abort_addr();
    spi_start();
    checks++;
    if (xfer_active !== 1'b1) begin
      errors++;
      $display("FAIL addr_active: got %b, required 1", xfer_active);
    end
    send_addr(2, 5);
    spi_stop();
    checks++;
    if (xfer_active !== 1'b0) begin
      errors++;
      $display("FAIL abort_active: got %b, required 0", xfer_active);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_drained: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_zero_data();
    run_data_xfer(3, 32'h0, 0);
    checks++;
    if (bit_count !== '0) begin
      errors++;
      $display("FAIL zero_bit_count: got %0d, required 0", bit_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL zero_drained: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_miso();
    logic       prev;
    logic [3:0] pattern;
    pattern = 4'b1011;
    prev = 1'b0;
    chan_shift_in = '0;
    expect_ev(EV_CAP, 4, 1'b0);
    spi_start();
    send_addr(4, ADDR_BITS);
    tick(4);
    for (int i = 3; i >= 0; i--) begin
      chan_shift_in[4] = pattern[i];
      chan_shift_in[3] = ~pattern[i];
      #1;
      checks++;
      if (spi_miso !== prev) begin
        errors++;
        $display("FAIL miso_latency: got %b, required %b (previous value)", spi_miso, prev);
      end
      tick(1);
      checks++;
      if (spi_miso !== pattern[i]) begin
        errors++;
        $display("FAIL miso_follow: got %b, required %b", spi_miso, pattern[i]);
      end
      prev = pattern[i];
      tick(2);
    end
    spi_stop();
    checks++;
    if (spi_miso !== 1'b0) begin
      errors++;
      $display("FAIL miso_after_ss: got %b, required 0", spi_miso);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL miso_drained: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
    chan_shift_in = '0;
  endtask

  task automatic test_back_to_back();
    run_data_xfer(7, 32'h1, 1);
    checks++;
    if (bit_count !== 16'd1) begin
      errors++;
      $display("FAIL last_chan_bit_count: got %0d, required 1", bit_count);
    end
    expect_ev(EV_ERR, 0, 1'b0);
    spi_start();
    send_addr(8, ADDR_BITS);
    spi_stop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL boundary_drained: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    expect_ev(EV_CAP, 2, 1'b0);
    for (int i = 0; i < 6; i++) expect_ev(EV_SHIFT, 2, i[0]);
    spi_start();
    send_addr(2, ADDR_BITS);
    for (int i = 0; i < 6; i++) spi_bit(i[0]);
    tick(2);
    scan_reset = 1'b1;
    tick(3);
    checks++;
    if ({spi_miso, chan_shift_data, xfer_active, addr_err, chan_shift_ena, chan_capture,
         chan_update} !== '0 || bit_count !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got active=%b count=%0d ena=%b upd=%b, required all 0",
               xfer_active, bit_count, chan_shift_ena, chan_update);
    end
    scan_reset = 1'b0;
    tick(12);
    checks++;
    if (xfer_active !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_restart: got %b, required 0", xfer_active);
    end
    spi_ss_ = 1'b1;
    tick(8);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_drained: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
    run_data_xfer(2, 32'h3C9, 12);
    checks++;
    if (bit_count !== 16'd12) begin
      errors++;
      $display("FAIL post_reset_bit_count: got %0d, required 12", bit_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_drained: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_err();
    test_abort_addr();
    test_zero_data();
    test_miso();
    test_back_to_back();
    test_reset_mid();
    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icetap_spi_bridge.md
ICETAP_SPI_BRIDGE -- requirements
Module: icetap_spi_bridge

Interface
REQ-001 The block SHALL have parameter NUM_CHAN, default 8, giving the number of scan channels (1..255).
REQ-002 The block SHALL have parameter ADDR_BITS, default 8, giving the address-phase length in bits (must satisfy 2**ADDR_BITS >= NUM_CHAN).
REQ-003 The block SHALL have parameter CNT_BITS, default 16, giving the data-bit counter width.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, giving the flop count of each input synchroniser (>= 2).
REQ-005 scan_clk  in  1  sole clock; all logic is on its rising edge.
REQ-006 scan_reset  in  1  synchronous, active-high reset.
REQ-007 spi_clk  in  1  asynchronous SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-008 spi_ss_  in  1  asynchronous active-low slave select.
REQ-009 spi_mosi  in  1  asynchronous SPI data in.
REQ-010 spi_miso  out  1  registered SPI data out.
REQ-011 chan_shift_ena  out  NUM_CHAN  one-hot, one-cycle shift strobe per channel.
REQ-012 chan_shift_data  out  1  shift data shared by all channels.
REQ-013 chan_capture  out  NUM_CHAN  one-cycle capture pulse at end of the address phase.
REQ-014 chan_update  out  NUM_CHAN  one-cycle update pulse at end of the transaction.
REQ-015 chan_shift_in  in  NUM_CHAN  serial return data per channel.
REQ-016 xfer_active  out  1  high while in ADDR or DATA.
REQ-017 bit_count  out  CNT_BITS  data bits shifted in the current or last transaction.
REQ-018 addr_err  out  1  one-cycle pulse when the address is >= NUM_CHAN.

Function
REQ-019 spi_clk, spi_ss_ and spi_mosi SHALL each pass through SYNC_STAGES flops; all logic SHALL use only the synchronised versions.
REQ-020 An SPI edge event SHALL be synchronised spi_clk high in the current cycle and low in the previous cycle.
REQ-021 FSM states: IDLE, ADDR, DATA, IGNORE.
REQ-022 IDLE -> ADDR on a synchronised ss_ falling edge; addr shift register and bit_count clear; xfer_active rises in the same cycle.
REQ-023 ADDR: each edge event shifts synchronised mosi into addr, MSB first; after ADDR_BITS events, go to DATA if addr < NUM_CHAN, otherwise go to IGNORE and pulse addr_err.
REQ-024 chan_capture[addr] SHALL pulse in the cycle after the ADDR->DATA transition.
REQ-025 DATA: each edge event pulses chan_shift_ena[addr] for one cycle with chan_shift_data = synchronised mosi, and increments bit_count.
REQ-026 bit_count SHALL saturate at all-ones.
REQ-027 Synchronised ss_ rising edge from DATA: pulse chan_update[addr] only if bit_count != 0, then go to IDLE.
REQ-028 Synchronised ss_ rising edge from ADDR or IGNORE: go to IDLE with no capture or update pulse.
REQ-029 IGNORE: edge events are discarded; no channel outputs are asserted.
REQ-030 An ss_ rising edge in the same cycle as an edge event SHALL take priority; that edge event is dropped.
REQ-031 spi_miso SHALL register chan_shift_in[addr] every cycle in DATA, and 0 in all other states.
REQ-032 At most one bit SHALL be set across chan_shift_ena, chan_capture and chan_update in any cycle.
REQ-033 bit_count SHALL hold its value in IDLE until the next transaction starts.

Reset
REQ-034 While scan_reset is high, the FSM SHALL be IDLE, synchronisers SHALL be loaded with ss_=1 and clk=0, and addr and bit_count SHALL be 0.
REQ-035 All outputs SHALL be 0 during reset.
REQ-036 Reset asserted mid-transaction SHALL abort it with no update pulse; after release, a new ss_ falling edge is required to start a transaction.

Verification
REQ-037 Addr 0x02 followed by 12 data bits, NUM_CHAN=8 -> one chan_capture[2] pulse; 12 chan_shift_ena[2] pulses carrying the MOSI bits in order; one chan_update[2] pulse; bit_count=12.
REQ-038 Addr 0x09 with NUM_CHAN=8 -> addr_err pulses once; no chan_* activity; spi_miso stays 0.
REQ-039 ss_ raised after 5 address bits -> FSM returns to IDLE; no pulses on any output.
REQ-040 Addr 0x03 followed by 0 data bits -> chan_capture[3] pulses; no chan_update pulse.
REQ-041 chan_shift_in[4] driven 1,0,1,1 during a transaction to channel 4 -> spi_miso follows with 1 cycle of latency; spi_miso is 0 after ss_ rises.
REQ-042 scan_reset asserted after 6 data bits -> all outputs 0; no update pulse; the next full transaction behaves as in REQ-037.
